tank_pos_arbiter: RTL and testbench
===================================

# tank_pos_arbiter

Owns the single registered tank-position and mouse-position stage that feeds the renderer. Two requesters compete for that stage: the local movement controller (A) and the remote UART position receiver (B). The block grants one requester per frame with round-robin fairness and commits only during vertical blanking, so the picture never tears. Mouse coordinates are sampled at the same instant, which makes all four outputs frame-coherent.

## Interface
Parameters:
- X_MAX, 10'd768, largest legal tank X (clamp build only)
- Y_MAX, 10'd568, largest legal tank Y (clamp build only)
- XPOS_MAX, 12'd799, largest legal mouse X (clamp build only)
- YPOS_MAX, 12'd599, largest legal mouse Y (clamp build only)

Ports:
- clk  in  1  system pixel clock
- rst  in  1  asynchronous, active-high reset
- vblank  in  1  vertical blanking flag, synchronous to clk
- req_a / req_b  in  1  update request from A / B; held until ack
- x_a, y_a / x_b, y_b  in  10 each  proposed tank position; stable while req is high
- xpos, ypos  in  12 each  live mouse position
- ack_a / ack_b  out  1  one-cycle commit acknowledge
- Data_X_out, Data_Y_out  out  10 each  committed tank position
- xpos_out, ypos_out  out  12 each  frame-sampled mouse position
- owner  out  1  source of the last commit (0=A, 1=B)
- frame_cnt  out  8  count of vblank rising edges, wraps 255→0

## Operation
- Internal vblank_d register detects the vblank rising edge (vblank=1, vblank_d=0).
- State machine:
  - IDLE: waits for a rising edge, then goes to ARB. frame_cnt increments on this edge.
  - ARB (exactly 1 cycle): samples req_a and req_b.
    - Only one requester asserted: that requester is granted.
    - Both asserted: grant goes to the requester that is not last_grant.
    - Neither asserted: no grant.
    - On the clock edge ending ARB, the granted x/y is registered into Data_X_out/Data_Y_out, and xpos/ypos is always registered into xpos_out/ypos_out.
    - With a grant: the matching ack goes to 1, owner and last_grant are set to the winner, and the next state is ACK.
    - With no grant: tank outputs are unchanged, and the next state is WAIT.
  - ACK (1 cycle): ack returns to 0. Next state is WAIT.
  - WAIT: stays until vblank=0, then goes to IDLE.
- There is at most one commit per frame. The losing requester keeps req high and is served in a later frame.
- A requester that drops req before ARB is not served and does not receive an ack.
- A vblank falling edge during ARB or ACK does not abort the commit.
- Reset values: Data_X_out=0, Data_Y_out=0, xpos_out=0, ypos_out=0, ack_a=0, ack_b=0, owner=0, frame_cnt=0, last_grant=1 (so A wins the first tie), vblank_d=0, state=IDLE.
- Asserting rst mid-operation forces all of these values immediately, including a pending ack. After rst is released, a commit happens only on a fresh vblank rising edge.

## Timing
- E0 is the edge at which vblank=1 is first registered.
- After E0: state=ARB.
- At E1: outputs update and ack goes high.
- At E2: ack goes low.
- Latency from the vblank rise to the outputs is 2 cycles. ack width is exactly 1 cycle.
- vblank must stay high for at least 3 cycles; real blanking lasts far longer.
- A request raised in the same cycle as ARB counts.
- ack is never asserted for both requesters in the same cycle.

## Configuration
- POS_CLAMP_EN defined:
  - Committed X/Y values are saturated to X_MAX/Y_MAX.
  - xpos/ypos are saturated to XPOS_MAX/YPOS_MAX before registering.
  - Comparisons are unsigned, at full port width.
- POS_CLAMP_EN undefined: values pass through unchanged, and the parameters are unused.

## Structure
- Package tank_pos_pkg holds:
  - the state encoding (IDLE, ARB, ACK, WAIT);
  - the owner encodings OWN_A=0 and OWN_B=1;
  - default screen-limit constants.
- Sub-module rr_arbiter2 is a combinational two-input round-robin grant that takes last_grant as an input. The last_grant register stays in the parent.

## Test plan
- After reset: all outputs 0 and frame_cnt=0. With req_a=1, x_a=100, y_a=200, xpos=300, ypos=400 and a vblank rise: Data_X_out=100, Data_Y_out=200, xpos_out=300 and ypos_out=400 at E1; ack_a high for 1 cycle; owner=0.
- Both requesting for three consecutive frames (A=(10,10), B=(20,20)): commits are A, B, A; owner toggles 0,1,0; the loser's ack stays 0.
- No request in a frame: Data_X_out and Data_Y_out hold their previous values, xpos_out and ypos_out still refresh, and no ack is asserted.
- rst pulsed in the ACK cycle: ack drops asynchronously, all outputs return to 0, and no commit occurs until the next vblank rise. Also run 256 frames and check frame_cnt wraps to 0.
- POS_CLAMP_EN build: x_a=1000, y_a=1000, xpos=4095 → outputs 768, 568, 799. Without the macro: outputs 1000, 1000, 4095.
- Request changes while vblank is held high for 100 cycles: exactly one commit occurs in that frame.

Source files
------------

// File: rtl/tank_pos_pkg.sv
// Shared encodings and default screen limits for the tank/mouse position commit stage.
package tank_pos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    ACK  = 2'd2,
    WAIT = 2'd3
  } state_t;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  localparam logic [9:0]  X_MAX_DEF    = 10'd768;
  localparam logic [9:0]  Y_MAX_DEF    = 10'd568;
  localparam logic [11:0] XPOS_MAX_DEF = 12'd799;
  localparam logic [11:0] YPOS_MAX_DEF = 12'd599;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant; the requester that did not win last time wins a tie.
module rr_arbiter2
  import tank_pos_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_grant,
  output logic grant_vld,
  output logic grant_owner
);

  always_comb begin
    grant_vld   = req_a | req_b;
    grant_owner = OWN_A;
    if (req_a && req_b)
      grant_owner = (last_grant == OWN_A) ? OWN_B : OWN_A;
    else if (req_b)
      grant_owner = OWN_B;
  end

endmodule

// File: rtl/tank_pos_arbiter.sv
// Frame-coherent commit of tank and mouse positions during vblank, one round-robin grant per frame.
// Optional saturation of committed values is enabled by defining POS_CLAMP_EN.
module tank_pos_arbiter
  import tank_pos_pkg::*;
#(
  parameter logic [9:0]  X_MAX    = X_MAX_DEF,
  parameter logic [9:0]  Y_MAX    = Y_MAX_DEF,
  parameter logic [11:0] XPOS_MAX = XPOS_MAX_DEF,
  parameter logic [11:0] YPOS_MAX = YPOS_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblank,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [9:0]  x_a,
  input  logic [9:0]  y_a,
  input  logic [9:0]  x_b,
  input  logic [9:0]  y_b,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        ack_a,
  output logic        ack_b,
  output logic [9:0]  Data_X_out,
  output logic [9:0]  Data_Y_out,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic        owner,
  output logic [7:0]  frame_cnt
);

  function automatic logic [9:0] sat10(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [11:0] sat12(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t      state, state_nxt;
  logic        vblank_d;
  logic        last_grant;
  logic        rise;
  logic        grant_vld;
  logic        grant_owner;
  logic        commit;
  logic        ack_a_nxt, ack_b_nxt;
  logic [9:0]  x_sel, y_sel, x_com, y_com;
  logic [11:0] xp_com, yp_com;

  assign rise = vblank & ~vblank_d;

  rr_arbiter2 u_rr (
    .req_a       (req_a),
    .req_b       (req_b),
    .last_grant  (last_grant),
    .grant_vld   (grant_vld),
    .grant_owner (grant_owner)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vblank_d <= 1'b0;
    end else begin
      state    <= state_nxt;
      vblank_d <= vblank;
    end
  end

  // ARB and ACK always run to completion, even if vblank falls underneath them.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = ARB;
      ARB:     state_nxt = grant_vld ? ACK : WAIT;
      ACK:     state_nxt = WAIT;
      WAIT:    if (!vblank) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    commit    = (state == ARB);
    ack_a_nxt = commit & grant_vld & (grant_owner == OWN_A);
    ack_b_nxt = commit & grant_vld & (grant_owner == OWN_B);
    x_sel     = (grant_owner == OWN_B) ? x_b : x_a;
    y_sel     = (grant_owner == OWN_B) ? y_b : y_a;
`ifdef POS_CLAMP_EN
    x_com     = sat10(x_sel, X_MAX);
    y_com     = sat10(y_sel, Y_MAX);
    xp_com    = sat12(xpos, XPOS_MAX);
    yp_com    = sat12(ypos, YPOS_MAX);
`else
    x_com     = x_sel;
    y_com     = y_sel;
    xp_com    = xpos;
    yp_com    = ypos;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      Data_X_out <= '0;
      Data_Y_out <= '0;
      xpos_out   <= '0;
      ypos_out   <= '0;
      owner      <= OWN_A;
      last_grant <= OWN_B;
      frame_cnt  <= '0;
    end else begin
      ack_a <= ack_a_nxt;
      ack_b <= ack_b_nxt;
      if (rise)
        frame_cnt <= frame_cnt + 8'd1;
      // Mouse position refreshes every frame; tank position only on a grant.
      if (commit) begin
        xpos_out <= xp_com;
        ypos_out <= yp_com;
        if (grant_vld) begin
          Data_X_out <= x_com;
          Data_Y_out <= y_com;
          owner      <= grant_owner;
          last_grant <= grant_owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_tank_pos_arbiter.sv
// Scoreboard bench for tank_pos_arbiter; expected values follow POS_CLAMP_EN when defined.
module tb_tank_pos_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [9:0]  x_a = '0, y_a = '0, x_b = '0, y_b = '0;
  logic [11:0] xpos = '0, ypos = '0;
  logic        ack_a, ack_b, owner;
  logic [9:0]  Data_X_out, Data_Y_out;
  logic [11:0] xpos_out, ypos_out;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ack_a;
    logic        ack_b;
    logic        owner;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [11:0] xp;
    logic [11:0] yp;
  } exp_t;

  exp_t sb[$];

  logic        m_last;
  logic        m_owner;
  logic [9:0]  m_x, m_y;
  logic [11:0] m_xp, m_yp;
  logic [7:0]  m_frames;

  tank_pos_arbiter dut (
    .clk(clk), .rst(rst), .vblank(vblank),
    .req_a(req_a), .req_b(req_b),
    .x_a(x_a), .y_a(y_a), .x_b(x_b), .y_b(y_b),
    .xpos(xpos), .ypos(ypos),
    .ack_a(ack_a), .ack_b(ack_b),
    .Data_X_out(Data_X_out), .Data_Y_out(Data_Y_out),
    .xpos_out(xpos_out), .ypos_out(ypos_out),
    .owner(owner), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && ack_a && ack_b) begin
      errors++;
      $display("FAIL dual_ack: ack_a=%0b ack_b=%0b required at most one high", ack_a, ack_b);
    end

  function automatic logic [9:0] exp_clamp10(input logic [9:0] v, input int lim);
`ifdef POS_CLAMP_EN
    if (int'(v) > lim) return 10'(lim);
`endif
    return v;
  endfunction

  function automatic logic [11:0] exp_clamp12(input logic [11:0] v, input int lim);
`ifdef POS_CLAMP_EN
    if (int'(v) > lim) return 12'(lim);
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_last = 1'b1; m_owner = 1'b0; m_x = '0; m_y = '0;
    m_xp = '0; m_yp = '0; m_frames = '0;
    sb.delete();
  endtask

  task automatic model_arb(input logic ra, input logic rb);
    exp_t e;
    logic win;
    win = (ra && rb) ? ~m_last : rb;
    if (ra || rb) begin
      m_x = exp_clamp10(win ? x_b : x_a, 768);
      m_y = exp_clamp10(win ? y_b : y_a, 568);
      m_owner = win;
      m_last = win;
    end
    m_xp = exp_clamp12(xpos, 799);
    m_yp = exp_clamp12(ypos, 599);
    e.ack_a = ra && (!rb || !win);
    e.ack_b = rb && win;
    e.owner = m_owner; e.x = m_x; e.y = m_y; e.xp = m_xp; e.yp = m_yp;
    sb.push_back(e);
  endtask

  task automatic check_commit(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb_empty: no expected entry queued", tag);
      return;
    end
    e = sb.pop_front();
    checks++; if (ack_a !== e.ack_a) begin errors++; $display("FAIL %s_ack_a: got %0b want %0b", tag, ack_a, e.ack_a); end
    checks++; if (ack_b !== e.ack_b) begin errors++; $display("FAIL %s_ack_b: got %0b want %0b", tag, ack_b, e.ack_b); end
    checks++; if (owner !== e.owner) begin errors++; $display("FAIL %s_owner: got %0b want %0b", tag, owner, e.owner); end
    checks++; if (Data_X_out !== e.x) begin errors++; $display("FAIL %s_x: got %0d want %0d", tag, Data_X_out, e.x); end
    checks++; if (Data_Y_out !== e.y) begin errors++; $display("FAIL %s_y: got %0d want %0d", tag, Data_Y_out, e.y); end
    checks++; if (xpos_out !== e.xp) begin errors++; $display("FAIL %s_xpos: got %0d want %0d", tag, xpos_out, e.xp); end
    checks++; if (ypos_out !== e.yp) begin errors++; $display("FAIL %s_ypos: got %0d want %0d", tag, ypos_out, e.yp); end
  endtask

  // One complete frame: rise at E0, commit visible after E1, ack gone after E2.
  task automatic run_frame(input string tag, input logic ra, input logic rb, input bit late);
    if (!late) begin req_a = ra; req_b = rb; end
    @(negedge clk) vblank = 1'b1;
    @(posedge clk); #1;
    m_frames = m_frames + 8'd1;
    if (late) begin req_a = ra; req_b = rb; end
    model_arb(ra, rb);
    @(posedge clk); #1;
    check_commit(tag);
    @(posedge clk); #1;
    checks++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
      errors++; $display("FAIL %s_ack_width: got a=%0b b=%0b want 0 0", tag, ack_a, ack_b);
    end
    checks++;
    if (frame_cnt !== m_frames) begin
      errors++; $display("FAIL %s_frame_cnt: got %0d want %0d", tag, frame_cnt, m_frames);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk) vblank = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({ack_a, ack_b, owner, Data_X_out, Data_Y_out, xpos_out, ypos_out, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL %s: got ack=%0b%0b own=%0b x=%0d y=%0d xp=%0d yp=%0d fc=%0d want all 0",
               tag, ack_a, ack_b, owner, Data_X_out, Data_Y_out, xpos_out, ypos_out, frame_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single();
    x_a = 10'd100; y_a = 10'd200; xpos = 12'd300; ypos = 12'd400;
    run_frame("single_a", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_round_robin();
    x_a = 10'd10; y_a = 10'd10; x_b = 10'd20; y_b = 10'd20;
    for (int i = 0; i < 3; i++) begin
      xpos = 12'(50 + i); ypos = 12'(60 + i);
      run_frame($sformatf("rr%0d", i), 1'b1, 1'b1, 1'b0);
    end
    x_b = 10'd333; y_b = 10'd444;
    run_frame("single_b", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_no_request();
    x_a = 10'd77; y_a = 10'd88; xpos = 12'd11; ypos = 12'd22;
    run_frame("noreq", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_late_request_clamp();
    x_a = 10'd1000; y_a = 10'd1000; xpos = 12'd4095; ypos = 12'd4095;
    run_frame("clamp_late", 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_in_ack();
    x_a = 10'd123; y_a = 10'd321; xpos = 12'd5; ypos = 12'd6;
    req_a = 1'b1;
    @(negedge clk) vblank = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (ack_a !== 1'b1) begin errors++; $display("FAIL rst_ack_pre: got %0b want 1", ack_a); end
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    vblank = 1'b0;
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (ack_a !== 1'b0 || Data_X_out !== 10'd0) begin
      errors++; $display("FAIL rst_no_commit: got ack=%0b x=%0d want 0 0", ack_a, Data_X_out);
    end
    run_frame("rst_recover", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_frame_wrap();
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      xpos = 12'(i); ypos = 12'(i * 2);
      run_frame("wrap", 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (frame_cnt !== 8'd0) begin errors++; $display("FAIL frame_wrap: got %0d want 0", frame_cnt); end
  endtask

  task automatic test_long_vblank();
    int acks;
    acks = 0;
    x_a = 10'd55; y_a = 10'd66; xpos = 12'd7; ypos = 12'd8;
    req_a = 1'b1; req_b = 1'b0;
    @(negedge clk) vblank = 1'b1;
    m_frames = m_frames + 8'd1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (ack_a || ack_b) acks++;
      if (i >= 2) begin
        req_a = 1'($urandom_range(0, 1)); req_b = 1'($urandom_range(0, 1));
        x_b = 10'($urandom_range(0, 700));
      end
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL long_vblank_acks: got %0d want 1", acks); end
    checks++;
    if (Data_X_out !== 10'd55 || Data_Y_out !== 10'd66) begin
      errors++; $display("FAIL long_vblank_pos: got %0d,%0d want 55,66", Data_X_out, Data_Y_out);
    end
    checks++;
    if (frame_cnt !== m_frames) begin
      errors++; $display("FAIL long_vblank_fc: got %0d want %0d", frame_cnt, m_frames);
    end
    m_last = 1'b0; m_owner = 1'b0; m_x = 10'd55; m_y = 10'd66;
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk) vblank = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    x_a = 10'd1; y_a = 10'd2; x_b = 10'd3; y_b = 10'd4;
    run_frame("b2b0", 1'b1, 1'b1, 1'b0);
    run_frame("b2b1", 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_no_request();
    test_late_request_clamp();
    test_reset_in_ack();
    test_long_vblank();
    test_back_to_back();
    test_frame_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
